// File: rtl/cn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cn_pkg
// Description : Shared definitions for the combining-network consumer blocks:
//               lane count, bundle layout helpers and the apply FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cn_pkg;

    // Number of lanes in one combining-network output bundle.
    localparam int LANES          = 8;
    // Default width of a vertex ID / update word.
    localparam int DEFAULT_DATA_W = 32;

    // Apply-block states.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // LSB position of lane 'lane' inside a packed LANES*data_w vector.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

    // Stored bundle width: valid mask + destination IDs + updates.
    function automatic int bundle_w(input int data_w);
        return LANES + 2 * LANES * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word-fall-through read data.
//               Push and pop may occur in the same cycle, including when full.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push_i/wdata_i - write request / data
//               pop_i/rdata_o  - read request / head entry
//               full_o/empty_o - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push lands in, so a full FIFO can still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/update_apply_x8.sv
`default_nettype none
// ============================================================================
// Module      : update_apply_x8
// Description : Buffers 8-lane update bundles, serialises valid lanes one per
//               cycle and accumulates each update into a vertex-value RAM via
//               a two-stage read-modify-write pipeline with RAW forwarding.
//               A second RAM port lets the apply phase drain final values.
// Ports       : clk, rst                   - clock, sync active-high reset
//               InputValid/InDestVid/InUpdate/InReady - bundle input
//               RdEn/RdAddr/RdData/RdValid - 1-cycle-latency read port
//               InitDone                    - RAM clear finished
//               Idle                        - no work queued or in flight
//               ApplyCount/StatClr          - write counter (optional)
// Options     : `define UPDATE_APPLY_STAT_EN adds ApplyCount and StatClr.
// Revision    : 1.0 - initial release
// ============================================================================
module update_apply_x8
    import cn_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        InputValid,
    input  logic [DATA_W*LANES-1:0] InDestVid,
    input  logic [DATA_W*LANES-1:0] InUpdate,
    output logic                    InReady,
    input  logic                    RdEn,
    input  logic [ADDR_W-1:0]       RdAddr,
    output logic [DATA_W-1:0]       RdData,
    output logic                    RdValid,
    output logic                    InitDone,
    output logic                    Idle
`ifdef UPDATE_APPLY_STAT_EN
    ,
    output logic [31:0]             ApplyCount,
    input  logic                    StatClr
`endif
);
    localparam int VERTEX_NUM = 2 ** ADDR_W;
    localparam int BUNDLE_W   = bundle_w(DATA_W);
    localparam int VEC_W      = DATA_W * LANES;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_addr_q;
    logic                run;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BUNDLE_W-1:0] fifo_wdata, fifo_rdata;

    logic [LANES-1:0]    head_mask_q, head_mask_d, mask_rest;
    logic [VEC_W-1:0]    head_dest_q, head_upd_q;

    logic                issue;
    logic [DATA_W-1:0]   issue_dest, issue_upd;

    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [DATA_W-1:0]   s1_upd_q, ram_rdata_q, s1_base, s1_sum;
    logic                fwd_valid_q;
    logic [ADDR_W-1:0]   fwd_addr_q;
    logic [DATA_W-1:0]   fwd_data_q;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_q [VERTEX_NUM];
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Vertex IDs wider than the RAM address are truncated by design.
    logic                unused_dest_hi;
    assign unused_dest_hi = ^issue_dest[DATA_W-1:ADDR_W];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_addr_q <= init_addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_addr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign run      = (state_q == ST_RUN);
    assign InitDone = run;
    assign InReady  = run && !fifo_full;

    // ------------------------------------------------------- bundle FIFO
    assign fifo_push  = InReady && (|InputValid);
    assign fifo_wdata = {InputValid, InDestVid, InUpdate};

    sync_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------ head / drain
    always_comb begin
        issue      = run && (head_mask_q != '0);
        issue_dest = '0;
        issue_upd  = '0;
        // Descending scan so the lowest set lane is the one that sticks.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (head_mask_q[i]) begin
                issue_dest = head_dest_q[lane_lsb(i, DATA_W) +: DATA_W];
                issue_upd  = head_upd_q[lane_lsb(i, DATA_W) +: DATA_W];
            end
        end
        mask_rest = head_mask_q & (head_mask_q - 1'b1);
        // Refill as the last lane issues so consecutive bundles have no gap.
        fifo_pop    = run && (mask_rest == '0) && !fifo_empty;
        head_mask_d = fifo_pop ? fifo_rdata[BUNDLE_W-1 -: LANES] : mask_rest;
    end

    always_ff @(posedge clk) begin
        if (rst) head_mask_q <= '0;
        else     head_mask_q <= head_mask_d;
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            head_dest_q <= fifo_rdata[2*VEC_W-1:VEC_W];
            head_upd_q  <= fifo_rdata[VEC_W-1:0];
        end
    end

    // ------------------------------------------------ RMW pipeline S0/S1
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= issue;
            fwd_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr_q  <= issue_dest[ADDR_W-1:0];
        s1_upd_q   <= issue_upd;
        fwd_addr_q <= s1_addr_q;
        fwd_data_q <= s1_sum;
    end

    // The RAM read in S0 misses a write landing on the same edge; the
    // forward register holds exactly that write.
    assign s1_base = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : ram_rdata_q;
    assign s1_sum  = s1_base + s1_upd_q;

    assign ram_we    = !run || s1_valid_q;
    assign ram_waddr = run ? s1_addr_q : init_addr_q;
    assign ram_wdata = run ? s1_sum : '0;

    // ------------------------------------------------ dual-port RAM
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
        ram_rdata_q <= ram_q[issue_dest[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= RdEn && run;
            if (RdEn && run) rd_data_q <= ram_q[RdAddr];
        end
    end

    assign RdValid = rd_valid_q;
    assign RdData  = rd_data_q;
    assign Idle    = run && fifo_empty && (head_mask_q == '0) && !s1_valid_q;

`ifdef UPDATE_APPLY_STAT_EN
    // ------------------------------------------------ write statistics
    logic [31:0] apply_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || StatClr)          apply_cnt_q <= '0;
        else if (run && s1_valid_q)  apply_cnt_q <= apply_cnt_q + 32'd1;
    end

    assign ApplyCount = apply_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_update_apply_x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_update_apply_x8
// Description : Self-checking bench for update_apply_x8 (ADDR_W=4,
//               FIFO_DEPTH=2). Final vertex values are predicted by a
//               per-address running sum updated on every accepted bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_update_apply_x8;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int FD = 2;
    localparam int NV = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      InputValid = '0;
    logic [DW*8-1:0] InDestVid = '0;
    logic [DW*8-1:0] InUpdate = '0;
    logic            InReady;
    logic            RdEn = 1'b0;
    logic [AW-1:0]   RdAddr = '0;
    logic [DW-1:0]   RdData;
    logic            RdValid;
    logic            InitDone;
    logic            Idle;
`ifdef UPDATE_APPLY_STAT_EN
    logic [31:0]     ApplyCount;
    logic            StatClr = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model   [NV];
    logic [DW-1:0] rd_vals [NV];
    logic          rd_ok   [NV];

    always #5 clk = ~clk;

    update_apply_x8 #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .InputValid (InputValid),
        .InDestVid  (InDestVid),
        .InUpdate   (InUpdate),
        .InReady    (InReady),
        .RdEn       (RdEn),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .RdValid    (RdValid),
        .InitDone   (InitDone),
        .Idle       (Idle)
`ifdef UPDATE_APPLY_STAT_EN
        ,
        .ApplyCount (ApplyCount),
        .StatClr    (StatClr)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- helpers
    task automatic clear_model();
        for (int i = 0; i < NV; i++) model[i] = '0;
    endtask

    // Drive one bundle and hold it until accepted; the model sums every
    // valid lane into its (low-bit) destination address on acceptance.
    task automatic send_bundle(input logic [7:0] v, input logic [DW*8-1:0] d,
                               input logic [DW*8-1:0] u);
        int waitc;
        logic [AW-1:0] idx;
        waitc = 0;
        @(negedge clk);
        InputValid = v;
        InDestVid  = d;
        InUpdate   = u;
        if (v == 8'h00) begin
            @(posedge clk);
        end else begin
            while (!InReady && waitc < 200) begin
                @(negedge clk);
                waitc++;
            end
            if (!InReady) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: InReady=%b after %0d cycles, required 1", InReady, waitc);
            end else begin
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    if (v[i]) begin
                        idx = d[DW*i +: AW];
                        model[idx] = model[idx] + u[DW*i +: DW];
                    end
                end
            end
        end
    endtask

    task automatic stop_inputs();
        @(negedge clk);
        InputValid = '0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (Idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_all();
        @(negedge clk);
        RdEn   = 1'b1;
        RdAddr = '0;
        for (int a = 0; a < NV; a++) begin
            @(negedge clk);
            rd_vals[a] = RdData;
            rd_ok[a]   = RdValid;
            if (a < NV - 1) RdAddr = AW'(a + 1);
            else            RdEn = 1'b0;
        end
    endtask

    task automatic do_reset(output int cyc);
        @(negedge clk);
        rst        = 1'b1;
        InputValid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_model();
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (InitDone) break;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        int cyc;
        logic early, rdv;
        clear_model();
        @(negedge clk);
        rst    = 1'b1;
        RdEn   = 1'b1;
        RdAddr = '0;
        repeat (3) @(negedge clk);
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL rst_inready: got %b want 0", InReady); end
        total++; if (RdValid !== 1'b0) begin bad++; $display("FAIL rst_rdvalid: got %b want 0", RdValid); end
        total++; if (RdData !== '0) begin bad++; $display("FAIL rst_rddata: got %h want 0", RdData); end
        total++; if (InitDone !== 1'b0) begin bad++; $display("FAIL rst_initdone: got %b want 0", InitDone); end
        total++; if (Idle !== 1'b0) begin bad++; $display("FAIL rst_idle: got %b want 0", Idle); end
        rst   = 1'b0;
        cyc   = 0;
        early = 1'b0;
        rdv   = 1'b0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (InReady && !InitDone) early = 1'b1;
            if (RdValid) rdv = 1'b1;
            if (InitDone) break;
        end
        RdEn = 1'b0;
        total++; if (cyc != 16) begin bad++; $display("FAIL init_cycles: got %0d want 16", cyc); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL inready_before_init: got %b want 0", early); end
        total++; if (rdv !== 1'b0) begin bad++; $display("FAIL rdvalid_in_init: got %b want 0", rdv); end
        read_all();
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_ok[a] !== 1'b1 || rd_vals[a] !== 32'd0) begin
                bad++;
                $display("FAIL init_clear addr%0d: got %h valid=%b want 0", a, rd_vals[a], rd_ok[a]);
            end
        end
    endtask

    task automatic test_distinct();
        logic [DW*8-1:0] d, u;
        logic ok;
        for (int i = 0; i < 8; i++) begin
            d[DW*i +: DW] = DW'(8 - i);
            u[DW*i +: DW] = 32'd1;
        end
        send_bundle(8'hFF, d, u);
        stop_inputs();
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL distinct_idle: got %b want 1", ok); end
        read_all();
        total++; if (rd_vals[1] !== 32'd1 || rd_vals[8] !== 32'd1) begin bad++; $display("FAIL distinct_ends: a1=%h a8=%h want 1", rd_vals[1], rd_vals[8]); end
        total++; if (rd_vals[0] !== 32'd0 || rd_vals[9] !== 32'd0) begin bad++; $display("FAIL distinct_untouched: a0=%h a9=%h want 0", rd_vals[0], rd_vals[9]); end
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_ok[a] !== 1'b1 || rd_vals[a] !== model[a]) begin
                bad++;
                $display("FAIL distinct addr%0d: got %h valid=%b want %h", a, rd_vals[a], rd_ok[a], model[a]);
            end
        end
    endtask

    // Single update into an empty block: written at the end of the third
    // cycle after acceptance, so a read sampled on that edge sees the old
    // value and one sampled a cycle later sees the new one.
    task automatic test_latency();
        logic [DW*8-1:0] d, u;
        logic [DW-1:0] old_v;
        d = '0;
        u = '0;
        d[DW-1:0] = 32'd10;
        u[DW-1:0] = 32'd5;
        old_v = model[10];
        send_bundle(8'h01, d, u);
        @(negedge clk);
        InputValid = '0;
        @(negedge clk);
        @(negedge clk);
        RdEn   = 1'b1;
        RdAddr = 4'd10;
        @(negedge clk);
        total++; if (RdValid !== 1'b1 || RdData !== old_v) begin bad++; $display("FAIL latency_same_edge: got %h valid=%b want %h", RdData, RdValid, old_v); end
        @(negedge clk);
        RdEn = 1'b0;
        total++; if (RdValid !== 1'b1 || RdData !== old_v + 32'd5) begin bad++; $display("FAIL latency_after: got %h valid=%b want %h", RdData, RdValid, old_v + 32'd5); end
    endtask

    task automatic test_repeat();
        logic [DW*8-1:0] d, u, d2;
        logic [31:0] r;
        int cyc;
        logic ok;
        do_reset(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL repeat_init_cycles: got %0d want 16", cyc); end
        r = 32'h2225_5151;  // lanes 7..0 = 2,2,2,5,5,1,5,1
        for (int i = 0; i < 8; i++) begin
            d[DW*i +: DW]  = DW'(8 - i);
            d2[DW*i +: DW] = {28'd0, r[4*i +: 4]};
            u[DW*i +: DW]  = 32'd1;
        end
        send_bundle(8'hFF, d, u);
        send_bundle(8'hFF, d2, u);
        stop_inputs();
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL repeat_idle: got %b want 1", ok); end
        read_all();
        total++; if (rd_vals[2] !== 32'd4) begin bad++; $display("FAIL repeat_addr2: got %h want 4", rd_vals[2]); end
        total++; if (rd_vals[5] !== 32'd4) begin bad++; $display("FAIL repeat_addr5: got %h want 4", rd_vals[5]); end
        total++; if (rd_vals[1] !== 32'd3) begin bad++; $display("FAIL repeat_addr1: got %h want 3", rd_vals[1]); end
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_vals[a] !== model[a]) begin bad++; $display("FAIL repeat addr%0d: got %h want %h", a, rd_vals[a], model[a]); end
        end
`ifdef UPDATE_APPLY_STAT_EN
        total++; if (ApplyCount !== 32'd16) begin bad++; $display("FAIL repeat_applycount: got %0d want 16", ApplyCount); end
`endif
    endtask

    task automatic test_backpressure();
        logic [DW*8-1:0] d, u;
        int cyc;
        logic ok;
        do_reset(cyc);
        for (int i = 0; i < 8; i++) begin
            d[DW*i +: DW] = $urandom;  // masked-off lanes carry junk
            u[DW*i +: DW] = $urandom;
        end
        d[0 +: DW]    = 32'd3;
        d[DW*7 +: DW] = 32'd3;
        u[0 +: DW]    = 32'd7;
        u[DW*7 +: DW] = 32'd7;
        send_bundle(8'h81, d, u);
        send_bundle(8'h81, d, u);
        send_bundle(8'h81, d, u);
        stop_inputs();
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL bp_inready_full: got %b want 0", InReady); end
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b want 1", ok); end
        read_all();
        total++; if (rd_vals[3] !== 32'd42) begin bad++; $display("FAIL bp_addr3: got %h want 42", rd_vals[3]); end
        // An all-zero mask must be dropped even though every lane points at 3.
        for (int i = 0; i < 8; i++) d[DW*i +: DW] = 32'd3;
        send_bundle(8'h00, d, u);
        stop_inputs();
        repeat (6) @(negedge clk);
        read_all();
        total++; if (rd_vals[3] !== 32'd42) begin bad++; $display("FAIL zero_mask_addr3: got %h want 42", rd_vals[3]); end
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_vals[a] !== model[a]) begin bad++; $display("FAIL zero_mask addr%0d: got %h want %h", a, rd_vals[a], model[a]); end
        end
    endtask

    task automatic test_wrap();
        logic [DW*8-1:0] d, u;
        logic ok;
        d = '0;
        u = '0;
        d[DW-1:0] = 32'd4;
        u[DW-1:0] = 32'hFFFF_FFFF - model[4];
        send_bundle(8'h01, d, u);
        u[DW-1:0] = 32'd2;
        send_bundle(8'h01, d, u);
        stop_inputs();
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_idle: got %b want 1", ok); end
        read_all();
        total++; if (rd_vals[4] !== 32'h0000_0001) begin bad++; $display("FAIL wrap_addr4: got %h want 00000001", rd_vals[4]); end
    endtask

    task automatic test_random();
        logic [DW*8-1:0] d, u;
        logic [7:0] v;
        logic ok;
        for (int n = 0; n < 40; n++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) v = 8'h00;
            for (int i = 0; i < 8; i++) begin
                d[DW*i +: DW] = $urandom;
                u[DW*i +: DW] = $urandom;
            end
            send_bundle(v, d, u);
            if ($urandom_range(0, 3) == 0) stop_inputs();
        end
        stop_inputs();
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL random_idle: got %b want 1", ok); end
        read_all();
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_ok[a] !== 1'b1 || rd_vals[a] !== model[a]) begin
                bad++;
                $display("FAIL random addr%0d: got %h valid=%b want %h", a, rd_vals[a], rd_ok[a], model[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW*8-1:0] d, u;
        int cyc;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) begin
                d[DW*i +: DW] = $urandom;
                u[DW*i +: DW] = $urandom_range(1, 1000);
            end
            send_bundle(8'hFF, d, u);
        end
        @(negedge clk);
        InputValid = '0;
        total++; if (InReady !== 1'b0 || Idle !== 1'b0) begin bad++; $display("FAIL midrst_busy: InReady=%b Idle=%b want 0 0", InReady, Idle); end
        do_reset(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL midrst_init_cycles: got %0d want 16", cyc); end
        repeat (4) @(negedge clk);
        total++; if (Idle !== 1'b1) begin bad++; $display("FAIL midrst_idle: got %b want 1", Idle); end
        read_all();
        for (int a = 0; a < NV; a++) begin
            total++;
            if (rd_vals[a] !== 32'd0) begin bad++; $display("FAIL midrst addr%0d: got %h want 0", a, rd_vals[a]); end
        end
`ifdef UPDATE_APPLY_STAT_EN
        total++; if (ApplyCount !== 32'd0) begin bad++; $display("FAIL midrst_applycount: got %0d want 0", ApplyCount); end
`endif
    endtask

    initial begin
        test_reset();
        test_distinct();
        test_latency();
        test_repeat();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
